// File: rtl/cla_v2_8bit_pkg.sv
// Shared sizing constants for the two-level 8-bit carry-lookahead adder.
package cla_v2_8bit_pkg;
    localparam int CLA_WIDTH   = 8;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = 2;
endpackage

// File: rtl/cla_v2_8bit_if.sv
// Operand/result bundle for the registered 8-bit adder.
interface cla_v2_8bit_if;
    import cla_v2_8bit_pkg::*;

    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
    logic                 cin;
    logic [CLA_WIDTH-1:0] sum;
    logic                 cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/cla_v2_8bit_group.sv
// 4-bit lookahead group: flat sum-of-products carries, group propagate/generate, no carry-out.
module cla_4bit_group
    import cla_v2_8bit_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 ci,
    output logic [CLA_GROUP-1:0] s,
    output logic                 P,
    output logic                 G
);
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a two-level expression of ci, p and g; no carry feeds another.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;

    assign P = &p;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/cla_v2_8bit.sv
// Registered 8-bit adder: two 4-bit lookahead groups, second-level carries, one output register.
module cla_v2_8bit
    import cla_v2_8bit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    cla_v2_8bit_if.slave  bus
);
    logic [CLA_NGROUPS-1:0] grp_p;
    logic [CLA_NGROUPS-1:0] grp_g;
    logic                   c4;
    logic                   c8;
    logic [CLA_WIDTH-1:0]   sum_p0;
    logic [CLA_WIDTH-1:0]   sum_p1;
    logic                   cout_p1;

    // Second level: both group carries come straight from cin and the group P/G terms.
    assign c4 = grp_g[0] | (grp_p[0] & bus.cin);
    assign c8 = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & bus.cin);

    cla_4bit_group u_grp_lo (
        .a  (bus.a[CLA_GROUP-1:0]),
        .b  (bus.b[CLA_GROUP-1:0]),
        .ci (bus.cin),
        .s  (sum_p0[CLA_GROUP-1:0]),
        .P  (grp_p[0]),
        .G  (grp_g[0])
    );

    cla_4bit_group u_grp_hi (
        .a  (bus.a[CLA_WIDTH-1:CLA_GROUP]),
        .b  (bus.b[CLA_WIDTH-1:CLA_GROUP]),
        .ci (c4),
        .s  (sum_p0[CLA_WIDTH-1:CLA_GROUP]),
        .P  (grp_p[1]),
        .G  (grp_g[1])
    );

    // p0 -> p1: output register; reset clears the result as well as dominating the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
        end else begin
            sum_p1  <= sum_p0;
            cout_p1 <= c8;
        end
    end

    assign bus.sum  = sum_p1;
    assign bus.cout = cout_p1;
endmodule

// File: tb/tb_cla_v2_8bit.sv
// Directed and random checks of the registered 8-bit adder against a plain-arithmetic model.
module tb_cla_v2_8bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    cla_v2_8bit_if bus ();

    cla_v2_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed cout/sum=%0d/%0d expected=%0d/%0d",
                   tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Drive one vector, let one edge capture it, then compare the registered result.
    task automatic apply(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic vr);
        logic [8:0] exp;
        bus.a   = va;
        bus.b   = vb;
        bus.cin = vc;
        rst     = vr;
        @(posedge clk);
        #1;
        exp = vr ? 9'd0 : (9'(va) + 9'(vb) + 9'(vc));
        check(tag, {bus.cout, bus.sum}, exp);
    endtask

    initial begin
        bus.a   = 8'd0;
        bus.b   = 8'd0;
        bus.cin = 1'b0;

        apply("reset0", 8'd0, 8'd0, 1'b0, 1'b1);
        apply("reset1", 8'd255, 8'd255, 1'b1, 1'b1);
        apply("basic_2p5", 8'd2, 8'd5, 1'b0, 1'b0);

        apply("s_1p1", 8'd1, 8'd1, 1'b0, 1'b0);
        apply("s_20p20c", 8'd20, 8'd20, 1'b1, 1'b0);
        apply("s_75p75c", 8'd75, 8'd75, 1'b1, 1'b0);
        apply("s_128p128", 8'd128, 8'd128, 1'b0, 1'b0);
        apply("s_200p20", 8'd200, 8'd20, 1'b0, 1'b0);

        apply("prop_ff_c1", 8'hFF, 8'h00, 1'b1, 1'b0);
        apply("prop_ff_c0", 8'hFF, 8'h00, 1'b0, 1'b0);
        apply("prop_00ff_c1", 8'h00, 8'hFF, 1'b1, 1'b0);

        apply("grp_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0);
        apply("grp_f0_10", 8'hF0, 8'h10, 1'b0, 1'b0);
        apply("grp_0f_00_c1", 8'h0F, 8'h00, 1'b1, 1'b0);
        apply("grp_08_08", 8'h08, 8'h08, 1'b0, 1'b0);

        apply("mid_reset", 8'd255, 8'd255, 1'b1, 1'b1);
        apply("after_reset", 8'd3, 8'd4, 1'b0, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            apply("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            apply("random_rst", 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
